conv_compute_ctrl: RTL and testbench

Sequencer for the 2D-convolution datapath. When the input memories report `inputs_loaded`, it walks every valid output position and every kernel tap, drives `X_read_addr`/`W_read_addr` into the input memories, and emits aligned MAC control strobes to the multiply-accumulate stage. It applies output backpressure at window granularity and pulses `compute_finished` so the input memories release and accept the next matrix.

---
 rtl/conv_compute_ctrl.sv | 138 +++++++++++++
 tb/tb_conv_compute_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/conv_compute_ctrl.sv
// Convolution sequencer: walks output windows and kernel taps, drives X/W read addresses and MAC strobes.
// Optional cycle counter enabled by defining CONV_CTRL_PERF_EN.
module conv_compute_ctrl #(
  parameter int R         = 9,
  parameter int C         = 8,
  parameter int MAXK      = 4,
  parameter int DRAIN_CYC = 4,
  localparam int K_BITS      = $clog2(MAXK+1),
  localparam int X_ADDR_BITS = $clog2(R*C),
  localparam int W_ADDR_BITS = $clog2(MAXK*MAXK)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inputs_loaded,
  input  logic [K_BITS-1:0]      K,
  input  logic                   out_ready,
  output logic [X_ADDR_BITS-1:0] X_read_addr,
  output logic [W_ADDR_BITS-1:0] W_read_addr,
  output logic                   mac_valid,
  output logic                   mac_first,
  output logic                   mac_last,
  output logic                   compute_finished,
  output logic [31:0]            perf_cycles
);

  localparam int I_BITS = $clog2(R+1);
  localparam int J_BITS = $clog2(C+1);
  localparam int D_BITS = $clog2(DRAIN_CYC+1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic [I_BITS-1:0] i_q;
  logic [J_BITS-1:0] j_q;
  logic [K_BITS-1:0] m_q, n_q;
  logic [D_BITS-1:0] d_q;

  // [0]: tap issued last cycle (address now on the bus), [1]: memory data valid
  logic [1:0] vld_pipe, first_pipe, last_pipe;

  logic                   k_ok, win_start, issue, tap_last, job_last;
  logic [K_BITS-1:0]      k_last;
  logic [I_BITS-1:0]      or_last;
  logic [J_BITS-1:0]      oc_last;
  logic [X_ADDR_BITS-1:0] x_row, x_nx;
  logic [W_ADDR_BITS-1:0] w_nx;

  // K>MAXK would index past the W memory, so it is rejected alongside the grid limits
  assign k_ok      = (K != '0) && (int'(K) <= R) && (int'(K) <= C) && (int'(K) <= MAXK);
  assign k_last    = K - K_BITS'(1);
  assign or_last   = I_BITS'(R - int'(K));
  assign oc_last   = J_BITS'(C - int'(K));
  assign win_start = (m_q == '0) && (n_q == '0);
  assign issue     = (state == RUN) && (!win_start || out_ready);
  assign tap_last  = (m_q == k_last) && (n_q == k_last);
  assign job_last  = tap_last && (i_q == or_last) && (j_q == oc_last);

  assign x_row = X_ADDR_BITS'(i_q) + X_ADDR_BITS'(m_q);
  assign x_nx  = x_row * X_ADDR_BITS'(C) + X_ADDR_BITS'(j_q) + X_ADDR_BITS'(n_q);
  assign w_nx  = W_ADDR_BITS'(m_q) * W_ADDR_BITS'(K) + W_ADDR_BITS'(n_q);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (inputs_loaded) state_nx = k_ok ? RUN : DONE;
      RUN:     if (issue && job_last) state_nx = DRAIN;
      DRAIN:   if (d_q == D_BITS'(DRAIN_CYC-1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      m_q         <= '0;
      n_q         <= '0;
      d_q         <= '0;
      X_read_addr <= '0;
      W_read_addr <= '0;
      vld_pipe    <= '0;
      first_pipe  <= '0;
      last_pipe   <= '0;
    end else begin
      state      <= state_nx;
      vld_pipe   <= {vld_pipe[0],   issue};
      first_pipe <= {first_pipe[0], issue && win_start};
      last_pipe  <= {last_pipe[0],  issue && tap_last};
      d_q        <= (state == DRAIN) ? d_q + D_BITS'(1) : '0;
      if (state == IDLE && inputs_loaded) begin
        i_q <= '0;
        j_q <= '0;
        m_q <= '0;
        n_q <= '0;
      end else if (issue) begin
        X_read_addr <= x_nx;
        W_read_addr <= w_nx;
        if (n_q == k_last) begin
          n_q <= '0;
          if (m_q == k_last) begin
            m_q <= '0;
            if (j_q == oc_last) begin
              j_q <= '0;
              i_q <= (i_q == or_last) ? '0 : i_q + I_BITS'(1);
            end else begin
              j_q <= j_q + J_BITS'(1);
            end
          end else begin
            m_q <= m_q + K_BITS'(1);
          end
        end else begin
          n_q <= n_q + K_BITS'(1);
        end
      end
    end
  end

  assign mac_valid        = vld_pipe[1];
  assign mac_first        = first_pipe[1];
  assign mac_last         = last_pipe[1];
  assign compute_finished = (state == DONE);

`ifdef CONV_CTRL_PERF_EN
  logic [31:0] perf_q;
  // Stall cycles count too; the value survives into IDLE for software to read
  always_ff @(posedge clk) begin
    if (reset)                               perf_q <= '0;
    else if (state == IDLE && inputs_loaded) perf_q <= '0;
    else if (state != IDLE)                  perf_q <= perf_q + 32'd1;
  end
  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_conv_compute_ctrl.sv
// Directed bench for conv_compute_ctrl: address order, strobes, stalls, illegal K, reset and back-to-back jobs.
module tb_conv_compute_ctrl;
  localparam int R = 9, C = 8, MAXK = 15, DRAIN_CYC = 4;

  logic       clk, reset, inputs_loaded, out_ready;
  logic [3:0] K;
  logic [6:0] X_read_addr;
  logic [7:0] W_read_addr;
  logic       mac_valid, mac_first, mac_last, compute_finished;
  logic [31:0] perf_cycles;

  conv_compute_ctrl #(.R(R), .C(C), .MAXK(MAXK), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .reset(reset), .inputs_loaded(inputs_loaded), .K(K), .out_ready(out_ready),
    .X_read_addr(X_read_addr), .W_read_addr(W_read_addr), .mac_valid(mac_valid),
    .mac_first(mac_first), .mac_last(mac_last), .compute_finished(compute_finished),
    .perf_cycles(perf_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int xq[$], wq[$], fq[$], lq[$], tq[$];
  int nfin, t_fin;

  function automatic int exp_x(input int k, input int p);
    int oc, win, tap;
    oc  = C - k + 1;
    win = p / (k*k);
    tap = p % (k*k);
    return ((win / oc) + tap / k) * C + (win % oc) + (tap % k);
  endfunction

  // Runs one job; t counts edges from the one that samples inputs_loaded (t=1).
  // out_ready is low for RUN cycles [st_start, st_start+st_len).
  task automatic run_job(input int k, input int st_start, input int st_len, input int max_cyc);
    int px, pw;
    xq.delete(); wq.delete(); fq.delete(); lq.delete(); tq.delete();
    nfin = 0; t_fin = -1;
    px = X_read_addr; pw = W_read_addr;
    K = 4'(k); out_ready = 1'b1; inputs_loaded = 1'b1;
    for (int t = 1; t <= max_cyc; t++) begin
      @(posedge clk);
      @(negedge clk);
      if (mac_valid) begin
        xq.push_back(px); wq.push_back(pw);
        fq.push_back(int'(mac_first)); lq.push_back(int'(mac_last)); tq.push_back(t);
      end
      if (compute_finished) begin
        nfin++;
        if (t_fin < 0) t_fin = t;
        inputs_loaded = 1'b0;
      end
      px = X_read_addr; pw = W_read_addr;
      out_ready = !((t-1) >= st_start && (t-1) < st_start + st_len);
      if (t_fin >= 0 && t >= t_fin + 3) break;
    end
    inputs_loaded = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; inputs_loaded = 1'b0; out_ready = 1'b1; K = 4'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({X_read_addr, W_read_addr, mac_valid, mac_first, mac_last, compute_finished} !== '0 || perf_cycles !== 32'd0) begin
      fails++;
      $display("FAIL reset_outputs: x=%0d w=%0d v=%b f=%b l=%b cf=%b perf=%0d, all required 0",
               X_read_addr, W_read_addr, mac_valid, mac_first, mac_last, compute_finished, perf_cycles);
    end
    reset = 1'b0;
  endtask

  task automatic test_k3;
    int bad;
    int fx[9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    run_job(3, 0, 0, 600);
    tests++; if (xq.size() != 378) begin fails++; $display("FAIL k3_taps: got %0d want 378", xq.size()); end
    tests++; if (tq.size() == 0 || tq[0] != 3) begin fails++; $display("FAIL k3_first_valid_time: got %0d want 3", tq.size() ? tq[0] : -1); end
    bad = 0;
    for (int p = 0; p < 9 && p < xq.size(); p++) if (xq[p] != fx[p] || wq[p] != p) bad++;
    tests++; if (bad != 0 || xq.size() < 9) begin fails++; $display("FAIL k3_first_window: %0d wrong addrs, want 0 wrong", bad); end
    tests++; if (xq.size() != 378 || xq[369] != 53 || xq[377] != 71) begin fails++; $display("FAIL k3_last_window: got start %0d end %0d want 53 71", xq.size() > 377 ? xq[369] : -1, xq.size() > 377 ? xq[377] : -1); end
    bad = 0;
    for (int p = 0; p < xq.size(); p++)
      if (xq[p] != exp_x(3, p) || wq[p] != p % 9 || fq[p] != int'(p % 9 == 0) || lq[p] != int'(p % 9 == 8)) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL k3_sequence: %0d wrong taps want 0", bad); end
    bad = 0; foreach (lq[p]) bad += lq[p];
    tests++; if (bad != 42) begin fails++; $display("FAIL k3_last_count: got %0d want 42", bad); end
    tests++; if (t_fin != 378 + DRAIN_CYC + 1 || nfin != 1) begin fails++; $display("FAIL k3_finish: got t=%0d n=%0d want t=%0d n=1", t_fin, nfin, 378 + DRAIN_CYC + 1); end
`ifdef CONV_CTRL_PERF_EN
    tests++; if (perf_cycles !== 32'(378 + DRAIN_CYC + 1)) begin fails++; $display("FAIL k3_perf: got %0d want %0d", perf_cycles, 378 + DRAIN_CYC + 1); end
`else
    tests++; if (perf_cycles !== 32'd0) begin fails++; $display("FAIL k3_perf_off: got %0d want 0", perf_cycles); end
`endif
  endtask

  task automatic test_k1;
    int bad;
    run_job(1, 0, 0, 200);
    bad = 0;
    for (int p = 0; p < xq.size(); p++) if (xq[p] != p || wq[p] != 0 || fq[p] != 1 || lq[p] != 1) bad++;
    tests++; if (bad != 0 || xq.size() != 72) begin fails++; $display("FAIL k1_taps: got %0d taps %0d wrong want 72 taps 0 wrong", xq.size(), bad); end
    tests++; if (t_fin != 72 + DRAIN_CYC + 1 || nfin != 1) begin fails++; $display("FAIL k1_finish: got t=%0d n=%0d want t=%0d n=1", t_fin, nfin, 72 + DRAIN_CYC + 1); end
  endtask

  task automatic test_stall_k4;
    int bad;
    // out_ready low for RUN cycles 44..52: window 2 (taps 32..47) is mid-flight, window 3 waits 5 cycles
    run_job(4, 44, 9, 800);
    tests++; if (xq.size() != 480) begin fails++; $display("FAIL k4_taps: got %0d want 480", xq.size()); end
    tests++; if (xq.size() != 480 || tq[47] - tq[32] != 15 || tq[47] != 50) begin fails++; $display("FAIL k4_window2_solid: got span %0d end %0d want 15 50", xq.size() == 480 ? tq[47] - tq[32] : -1, xq.size() == 480 ? tq[47] : -1); end
    tests++; if (xq.size() != 480 || tq[48] != 56) begin fails++; $display("FAIL k4_window3_delay: got %0d want 56", xq.size() == 480 ? tq[48] : -1); end
    bad = 0;
    for (int p = 0; p < xq.size(); p++) if (xq[p] != exp_x(4, p) || wq[p] != p % 16) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL k4_sequence: %0d wrong taps want 0", bad); end
    tests++; if (t_fin != 485 + DRAIN_CYC + 1 || nfin != 1) begin fails++; $display("FAIL k4_finish: got t=%0d n=%0d want t=%0d n=1", t_fin, nfin, 485 + DRAIN_CYC + 1); end
`ifdef CONV_CTRL_PERF_EN
    tests++; if (perf_cycles !== 32'(480 + 5 + DRAIN_CYC + 1)) begin fails++; $display("FAIL k4_perf: got %0d want %0d", perf_cycles, 490); end
`endif
  endtask

  task automatic test_illegal_k;
    int ks[2] = '{0, 10};
    foreach (ks[q]) begin
      run_job(ks[q], 0, 0, 50);
      tests++; if (xq.size() != 0 || t_fin != 1 || nfin != 1) begin fails++; $display("FAIL illegal_k%0d: got taps=%0d t=%0d n=%0d want 0 1 1", ks[q], xq.size(), t_fin, nfin); end
    end
  endtask

  task automatic test_reset_mid_run;
    K = 4'd3; out_ready = 1'b1; inputs_loaded = 1'b1;
    for (int t = 1; t <= 8; t++) begin @(posedge clk); @(negedge clk); end
    tests++; if (mac_valid !== 1'b1) begin fails++; $display("FAIL midrun_active: got mac_valid=%b want 1", mac_valid); end
    reset = 1'b1; inputs_loaded = 1'b0;
    @(posedge clk); @(negedge clk);
    tests++;
    if ({X_read_addr, W_read_addr, mac_valid, mac_first, mac_last, compute_finished} !== '0 || perf_cycles !== 32'd0) begin
      fails++;
      $display("FAIL midrun_reset: x=%0d w=%0d v=%b f=%b l=%b cf=%b perf=%0d, all required 0",
               X_read_addr, W_read_addr, mac_valid, mac_first, mac_last, compute_finished, perf_cycles);
    end
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    tests++; if (mac_valid !== 1'b0 || compute_finished !== 1'b0) begin fails++; $display("FAIL midrun_quiet: got v=%b cf=%b want 0 0", mac_valid, compute_finished); end
    run_job(3, 0, 0, 600);
    tests++; if (xq.size() != 378 || xq[0] != 0 || tq[0] != 3 || t_fin != 383) begin fails++; $display("FAIL midrun_restart: got taps=%0d x0=%0d t_fin=%0d want 378 0 383", xq.size(), xq.size() ? xq[0] : -1, t_fin); end
  endtask

  task automatic test_back_to_back;
    run_job(2, 0, 0, 400);
    tests++; if (xq.size() != 224 || t_fin != 229 || nfin != 1) begin fails++; $display("FAIL b2b_job1: got taps=%0d t=%0d n=%0d want 224 229 1", xq.size(), t_fin, nfin); end
    run_job(2, 0, 0, 400);
    tests++; if (xq.size() != 224 || t_fin != 229 || nfin != 1 || xq[0] != 0 || xq[223] != 71) begin fails++; $display("FAIL b2b_job2: got taps=%0d t=%0d n=%0d want 224 229 1", xq.size(), t_fin, nfin); end
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      tests++; if (compute_finished !== 1'b0 || mac_valid !== 1'b0) begin fails++; $display("FAIL b2b_idle: got cf=%b v=%b want 0 0", compute_finished, mac_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_k3();
    test_k1();
    test_stall_k4();
    test_illegal_k();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
